// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tick_scheduler
// Purpose  : Three programmable-period clock-enable strobes, round-robin
//            arbitrated so at most one subsystem is strobed per cycle.
// Revision : 1.0  initial release
// ============================================================================
module tick_scheduler #(
    parameter int          PERIOD_WIDTH    = 32,
    parameter int unsigned DEFAULT_PERIOD0 = 500000,
    parameter int unsigned DEFAULT_PERIOD1 = 833333,
    parameter int unsigned DEFAULT_PERIOD2 = 1000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [1:0]              cfg_channel,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    output logic [2:0]              tick,
    output logic [2:0]              pending,
    output logic [2:0]              overrun,
    input  logic                    overrun_clear
);

    localparam logic [1:0] c_ST_RESET = 2'd0;
    localparam logic [1:0] c_ST_IDLE  = 2'd1;
    localparam logic [1:0] c_ST_APPLY = 2'd2;

    logic [PERIOD_WIDTH-1:0] r_period  [3];
    logic [PERIOD_WIDTH-1:0] r_counter [3];
    logic [2:0]              r_pending;
    logic [2:0]              r_overrun;
    logic [2:0]              r_tick;
    logic [1:0]              r_rr_ptr;
    logic [1:0]              r_state;
    logic                    r_cfg_ready;
    logic [1:0]              r_cfg_channel;
    logic [PERIOD_WIDTH-1:0] r_cfg_period;

    logic [2:0]              w_apply;
    logic [2:0]              w_expire;
    logic [2:0]              w_eligible;
    logic [2:0]              w_grant;
    logic [2:0]              w_new_overrun;
    logic [1:0]              w_grant_idx;
    logic                    w_grant_any;
    logic [2:0]              w_scan;
    logic [PERIOD_WIDTH-1:0] w_cfg_period_sat;

    assign w_cfg_period_sat = (r_cfg_period == '0) ? PERIOD_WIDTH'(1) : r_cfg_period;

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign w_apply[gi]  = (r_state == c_ST_APPLY) && (r_cfg_channel == 2'(gi));
        // A channel being reprogrammed has its counter reset, so it cannot expire.
        assign w_expire[gi] = enable && !w_apply[gi]
                              && (r_counter[gi] == r_period[gi] - PERIOD_WIDTH'(1));
    end

    // A channel under reprogramming is excluded so its pending bit is dropped, not ticked.
    assign w_eligible = r_pending & ~w_apply;

    always_comb begin
        w_grant     = 3'b000;
        w_grant_idx = r_rr_ptr;
        w_grant_any = 1'b0;
        w_scan      = 3'd0;
        for (int k = 0; k < 3; k++) begin
            w_scan = {1'b0, r_rr_ptr} + 3'(k);
            if (w_scan >= 3'd3) begin
                w_scan = w_scan - 3'd3;
            end
            if (!w_grant_any && w_eligible[w_scan[1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan[1:0];
            end
        end
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_new_overrun = w_expire & r_pending & ~w_grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_period[0]   <= PERIOD_WIDTH'(DEFAULT_PERIOD0);
            r_period[1]   <= PERIOD_WIDTH'(DEFAULT_PERIOD1);
            r_period[2]   <= PERIOD_WIDTH'(DEFAULT_PERIOD2);
            for (int i = 0; i < 3; i++) begin
                r_counter[i] <= '0;
            end
            r_pending     <= 3'b000;
            r_overrun     <= 3'b000;
            r_tick        <= 3'b000;
            r_rr_ptr      <= 2'd0;
            r_state       <= c_ST_RESET;
            r_cfg_ready   <= 1'b0;
            r_cfg_channel <= 2'd0;
            r_cfg_period  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_apply[i]) begin
                    r_period[i]  <= w_cfg_period_sat;
                    r_counter[i] <= '0;
                end else if (enable) begin
                    r_counter[i] <= w_expire[i] ? '0 : r_counter[i] + PERIOD_WIDTH'(1);
                end
            end

            // Expiry beats grant on the same channel; reprogramming beats both.
            r_pending <= ((r_pending & ~w_grant) | w_expire) & ~w_apply;
            r_overrun <= (overrun_clear ? 3'b000 : r_overrun) | w_new_overrun;
            r_tick    <= w_grant;
            if (w_grant_any) begin
                r_rr_ptr <= (w_grant_idx == 2'd2) ? 2'd0 : w_grant_idx + 2'd1;
            end

            case (r_state)
                c_ST_RESET: begin
                    r_state     <= c_ST_IDLE;
                    r_cfg_ready <= 1'b1;
                end
                c_ST_IDLE: begin
                    if (cfg_valid && r_cfg_ready) begin
                        r_state       <= c_ST_APPLY;
                        r_cfg_ready   <= 1'b0;
                        r_cfg_channel <= cfg_channel;
                        r_cfg_period  <= cfg_period;
                    end
                end
                c_ST_APPLY: begin
                    r_state     <= c_ST_IDLE;
                    r_cfg_ready <= 1'b1;
                end
                default: begin
                    r_state     <= c_ST_RESET;
                    r_cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign tick      = r_tick;
    assign pending   = r_pending;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_scheduler
// Purpose  : Self-checking bench for tick_scheduler (small default periods).
// Revision : 1.0  initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int PW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          overrun_clear = 1'b0;
    logic [1:0]    cfg_channel = 2'd0;
    logic [PW-1:0] cfg_period = '0;
    logic          cfg_ready;
    logic [2:0]    tick;
    logic [2:0]    pending;
    logic [2:0]    overrun;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] exp_q [$];
    logic [2:0] exp_t;

    tick_scheduler #(
        .PERIOD_WIDTH   (PW),
        .DEFAULT_PERIOD0(5),
        .DEFAULT_PERIOD1(7),
        .DEFAULT_PERIOD2(11)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_channel  (cfg_channel),
        .cfg_period   (cfg_period),
        .tick         (tick),
        .pending      (pending),
        .overrun      (overrun),
        .overrun_clear(overrun_clear)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Default periods 5/7/11 with enable high from cycle 0.
    function automatic logic [2:0] default_tick(input int n);
        case (n)
            6:       return 3'b001;
            8:       return 3'b010;
            11:      return 3'b001;
            12:      return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Leaves the bench at the negedge of cycle 0.
    task automatic do_reset(input logic en);
        @(negedge clock);
        reset = 1'b1; cfg_valid = 1'b0; overrun_clear = 1'b0; enable = en;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Returns at the negedge after the APPLY cycle.
    task automatic cfg_write(input logic [1:0] ch, input logic [PW-1:0] p);
        int waited = 0;
        while (cfg_ready !== 1'b1 && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        if (cfg_ready !== 1'b1) begin
            $display("FAIL cfg_ready_timeout: got %b want 1", cfg_ready);
            $fatal(1);
        end
        cfg_valid = 1'b1; cfg_channel = ch; cfg_period = p;
        @(negedge clock);
        cfg_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++; if (tick !== 3'b000) begin errors++; $display("FAIL reset_tick: got %b want 000", tick); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending: got %b want 000", pending); end
        checks++; if (overrun !== 3'b000) begin errors++; $display("FAIL reset_overrun: got %b want 000", overrun); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready: got %b want 0", cfg_ready); end
        for (int n = 0; n <= 12; n++) exp_q.push_back(default_tick(n));
        for (int n = 0; n <= 12; n++) begin
            exp_t = exp_q.pop_front();
            checks++;
            if (tick !== exp_t) begin errors++; $display("FAIL default_tick c%0d: got %b want %b", n, tick, exp_t); end
            if (n == 1) begin
                checks++;
                if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_cycle1: got %b want 1", cfg_ready); end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_same_period();
        do_reset(1'b0);
        cfg_write(2'd0, 16'd4); cfg_write(2'd1, 16'd4); cfg_write(2'd2, 16'd4);
        enable = 1'b1;
        for (int k = 0; k <= 12; k++)
            exp_q.push_back((k == 5 || k == 9) ? 3'b001 : (k == 6 || k == 10) ? 3'b010 :
                            (k == 7 || k == 11) ? 3'b100 : 3'b000);
        for (int k = 0; k <= 12; k++) begin
            exp_t = exp_q.pop_front();
            checks++;
            if (tick !== exp_t) begin errors++; $display("FAIL same_period_tick k%0d: got %b want %b", k, tick, exp_t); end
            if (k == 4) begin
                checks++;
                if (pending !== 3'b111) begin errors++; $display("FAIL same_period_pending: got %b want 111", pending); end
            end
            @(negedge clock);
        end
        checks++; if (overrun !== 3'b000) begin errors++; $display("FAIL same_period_overrun: got %b want 000", overrun); end
    endtask

    task automatic test_period_one();
        do_reset(1'b0);
        cfg_write(2'd0, 16'd1); cfg_write(2'd1, 16'd1); cfg_write(2'd2, 16'd1000);
        enable = 1'b1;
        for (int k = 0; k <= 9; k++)
            exp_q.push_back((k < 2) ? 3'b000 : (k % 2 == 0) ? 3'b001 : 3'b010);
        for (int k = 0; k <= 9; k++) begin
            exp_t = exp_q.pop_front();
            checks++;
            if (tick !== exp_t) begin errors++; $display("FAIL p1_tick k%0d: got %b want %b", k, tick, exp_t); end
            if (k == 1) begin
                checks++;
                if (pending !== 3'b011) begin errors++; $display("FAIL p1_pending: got %b want 011", pending); end
            end
            if (k == 3) begin
                checks++;
                if (overrun !== 3'b011) begin errors++; $display("FAIL p1_overrun_set: got %b want 011", overrun); end
            end
            if (k == 5) overrun_clear = 1'b1;
            if (k == 6) begin
                overrun_clear = 1'b0;
                checks++;
                if (overrun !== 3'b010) begin errors++; $display("FAIL p1_overrun_clear: got %b want 010", overrun); end
            end
            if (k == 7) begin
                checks++;
                if (overrun !== 3'b011) begin errors++; $display("FAIL p1_overrun_reset: got %b want 011", overrun); end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_pause();
        do_reset(1'b0);
        cfg_write(2'd0, 16'd4); cfg_write(2'd1, 16'd4); cfg_write(2'd2, 16'd1000);
        enable = 1'b1;
        for (int k = 0; k <= 16; k++)
            exp_q.push_back((k == 5 || k == 14) ? 3'b001 : (k == 6 || k == 15) ? 3'b010 : 3'b000);
        for (int k = 0; k <= 16; k++) begin
            exp_t = exp_q.pop_front();
            checks++;
            if (tick !== exp_t) begin errors++; $display("FAIL pause_tick k%0d: got %b want %b", k, tick, exp_t); end
            if (k == 4) begin
                checks++;
                if (pending !== 3'b011) begin errors++; $display("FAIL pause_pending: got %b want 011", pending); end
                enable = 1'b0;
            end
            if (k == 7) begin
                checks++;
                if (pending !== 3'b000) begin errors++; $display("FAIL pause_drained: got %b want 000", pending); end
            end
            if (k == 9) enable = 1'b1;
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        cfg_write(2'd0, 16'd1000); cfg_write(2'd1, 16'd1000);
        cfg_valid = 1'b1; cfg_channel = 2'd2; cfg_period = 16'd0;
        for (int k = 0; k <= 5; k++) begin
            checks++;
            if (cfg_ready !== ((k % 2) == 0)) begin
                errors++; $display("FAIL b2b_ready k%0d: got %b want %b", k, cfg_ready, ((k % 2) == 0));
            end
            @(negedge clock);
        end
        cfg_valid = 1'b0;
        enable = 1'b1;
        for (int k = 0; k <= 4; k++) exp_q.push_back((k >= 2) ? 3'b100 : 3'b000);
        for (int k = 0; k <= 4; k++) begin
            exp_t = exp_q.pop_front();
            checks++;
            if (tick !== exp_t) begin errors++; $display("FAIL zero_period_tick k%0d: got %b want %b", k, tick, exp_t); end
            if (k >= 1) begin
                checks++;
                if (pending !== 3'b100) begin errors++; $display("FAIL zero_period_pending k%0d: got %b want 100", k, pending); end
            end
            @(negedge clock);
        end
        checks++; if (overrun !== 3'b000) begin errors++; $display("FAIL zero_period_overrun: got %b want 000", overrun); end
    endtask

    task automatic test_cfg_collision();
        do_reset(1'b0);
        cfg_write(2'd1, 16'd1000); cfg_write(2'd2, 16'd1000); cfg_write(2'd0, 16'd4);
        enable = 1'b1;
        for (int k = 0; k <= 18; k++) exp_q.push_back((k == 11 || k == 17) ? 3'b001 : 3'b000);
        for (int k = 0; k <= 18; k++) begin
            exp_t = exp_q.pop_front();
            checks++;
            if (tick !== exp_t) begin errors++; $display("FAIL collide_tick k%0d: got %b want %b", k, tick, exp_t); end
            if (k == 2) begin
                cfg_valid = 1'b1; cfg_channel = 2'd0; cfg_period = 16'd6;
            end
            if (k == 3) begin
                cfg_valid = 1'b0;
                checks++;
                if (cfg_ready !== 1'b0) begin errors++; $display("FAIL collide_apply_ready: got %b want 0", cfg_ready); end
            end
            if (k == 4) begin
                checks++;
                if (pending !== 3'b000) begin errors++; $display("FAIL collide_pending: got %b want 000", pending); end
            end
            if (k == 12) begin
                cfg_valid = 1'b1; cfg_channel = 2'd3; cfg_period = 16'd2;
            end
            if (k == 13) cfg_valid = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        cfg_write(2'd0, 16'd4); cfg_write(2'd1, 16'd4); cfg_write(2'd2, 16'd4);
        enable = 1'b1;
        repeat (3) @(negedge clock);
        cfg_valid = 1'b1; cfg_channel = 2'd0; cfg_period = 16'd9;
        @(negedge clock);
        cfg_valid = 1'b0;
        checks++; if (pending !== 3'b111) begin errors++; $display("FAIL mid_pre_pending: got %b want 111", pending); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_ready: got %b want 0", cfg_ready); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (tick !== 3'b000) begin errors++; $display("FAIL mid_tick: got %b want 000", tick); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL mid_pending: got %b want 000", pending); end
        checks++; if (overrun !== 3'b000) begin errors++; $display("FAIL mid_overrun: got %b want 000", overrun); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", cfg_ready); end
        for (int n = 0; n <= 12; n++) exp_q.push_back(default_tick(n));
        for (int n = 0; n <= 12; n++) begin
            exp_t = exp_q.pop_front();
            checks++;
            if (tick !== exp_t) begin errors++; $display("FAIL mid_default_tick c%0d: got %b want %b", n, tick, exp_t); end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_same_period();
        test_period_one();
        test_pause();
        test_back_to_back();
        test_cfg_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_scheduler.md
# tick_scheduler

Generates one-cycle clock-enable strobes for three game subsystems (paddle update, ball update, score/display update) from the single system clock, each at its own run-time programmable period. It replaces per-subsystem divided clocks with enables in the system clock domain. It arbitrates expiries so at most one strobe fires per cycle, because the strobed subsystems share the single-port game-state RAM. Sits between the top-level game controller (which programs periods and pauses play) and the subsystem update logic.

## Interface

Parameters:
- PERIOD_WIDTH, 32, width of period registers and counters.
- DEFAULT_PERIOD0, 500000, channel 0 period in clock cycles after reset (paddle, 100 Hz at 50 MHz).
- DEFAULT_PERIOD1, 833333, channel 1 period after reset (ball).
- DEFAULT_PERIOD2, 1000000, channel 2 period after reset (score/display).

Ports:
- clock  in  1  system clock; the only clock; all logic on rising edge.
- reset  in  1  reset; synchronous and active-high.
- enable  in  1  1 = run counters, 0 = pause (counters hold).
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  scheduler can accept a configuration.
- cfg_channel  in  2  channel to reprogram (0..2; 3 = no-op).
- cfg_period  in  PERIOD_WIDTH  new period in cycles.
- tick  out  3  one-hot strobe, at most one bit high per cycle.
- pending  out  3  expiry awaiting grant, per channel.
- overrun  out  3  sticky: an expiry was lost on that channel.
- overrun_clear  in  1  clears all overrun bits.

## Operation

- Per channel i: period[i], counter[i] (0..period[i]-1), pending[i], overrun[i]. Round-robin pointer rr_ptr (0..2).
- Reset (reset=1 at an edge): period[i]=DEFAULT_PERIODi, counter=0, pending=0, overrun=0, tick=0, rr_ptr=0, cfg FSM to RESET state; cfg_ready=0.
- Counting (enable=1): if counter[i]==period[i]-1, the counter wraps to 0 and the channel expires; else it increments. With enable=0, counters hold and no expiries occur. Arbitration keeps draining pending.
- Expiry sets pending[i]. If pending[i] is already 1 and not granted on the same edge, pending stays 1 and overrun[i] is set.
- Arbitration at each edge: if pending≠0, grant g = first set bit scanning rr_ptr, rr_ptr+1, … mod 3. Then tick<=onehot(g), pending[g]<=0, rr_ptr<=(g+1) mod 3. Else tick<=0 and rr_ptr holds.
- Grant and expiry of the same channel on one edge: pending stays 1, no overrun.
- overrun_clear=1 clears all overrun bits. A new overrun set on the same edge wins.
- Config FSM states:
  - RESET: cfg_ready=0; goes to IDLE on the first edge with reset=0.
  - IDLE: cfg_ready=1; goes to APPLY on cfg_valid&&cfg_ready.
  - APPLY: cfg_ready=0; goes to IDLE next edge.
- Acceptance registers cfg_channel/cfg_period. In APPLY, for channel c≤2: period[c]<=max(cfg_period,1), counter[c]<=0, pending[c]<=0. APPLY overrides a same-edge expiry or grant of c (no tick for c that edge; another channel may be granted).
- cfg_channel==3: accepted, FSM passes through APPLY, no state change.
- Period value 0 is stored as 1. Period 1 expires every enabled cycle.

## Timing

- All outputs registered; no combinational input-to-output paths.
- Cycle 0 = first cycle with reset low. cfg_ready=1 from cycle 1.
- Channel with period P, enable=1 from cycle 0, no contention: expiry at edge P, pending high in cycle P, tick high in cycle P+1. Thereafter ticks are exactly P cycles apart.
- Expiry-to-tick latency is 1 cycle minimum. Each additional contending pending channel adds at most 1 cycle, so latency is ≤3 cycles.
- Config throughput: one request per 2 cycles. After a request is accepted at edge A (APPLY at A+1), the reprogrammed channel's first tick is in cycle A+1+P+1.
- Reset mid-operation: the next cycle shows tick=0, pending=0, overrun=0, cfg_ready=0, and any in-flight APPLY is discarded.

## Test plan

- Reset release with all defaults overridden to 4 via config: each channel ticks every 4 cycles. All three expire on one edge, so ticks appear in order ch0, ch1, ch2 in consecutive cycles with no overrun.
- Period 1 on channels 0 and 1, enable=1: ticks alternate ch0/ch1 every cycle; overrun[0] and overrun[1] set within 3 cycles; overrun_clear then clears them and they re-set.
- enable=0 while pending=3'b011: ch0 ticks next cycle, then ch1 the cycle after; counters frozen; ticks resume with the original phase after enable=1.
- cfg_period=0 to channel 2: stored as 1, ch2 pending every cycle. Back-to-back cfg_valid: cfg_ready low every other cycle, accept on alternate cycles only.
- Config to channel 0 on the same edge ch0 expires: no ch0 tick, counter restarts at 0, next tick P+1 cycles after APPLY. cfg_channel=3: no change to any channel.
- Assert reset while pending=3'b111 and FSM in APPLY: the following cycle shows tick=0, pending=0, cfg_ready=0, and periods are back to defaults.
